// File: rtl/musb_port_arbiter.sv
// Shares one memory port between iport and dport; grant registered 1 cycle after enable, held until ready/error/abort/watchdog.
// Masters stall via ready=0 while not owner; define MUSB_ARB_ROUND_ROBIN_EN for alternating priority instead of fixed dport > iport.
module musb_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iport_address,
  input  logic [31:0] iport_data_i,
  input  logic [3:0]  iport_wr,
  input  logic        iport_enable,
  output logic [31:0] iport_data_o,
  output logic        iport_ready,
  output logic        iport_error,
  input  logic [31:0] dport_address,
  input  logic [31:0] dport_data_i,
  input  logic [3:0]  dport_wr,
  input  logic        dport_enable,
  output logic [31:0] dport_data_o,
  output logic        dport_ready,
  output logic        dport_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_wr,
  output logic        mem_enable,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ready,
  input  logic        mem_error
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          wd_hit;
  logic          done;
`ifdef MUSB_ARB_ROUND_ROBIN_EN
  logic          prio_q, prio_d;  // 1 = dport first
`endif

  assign wd_hit = (TIMEOUT > 0) && (wdog_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wdog_q  <= '0;
`ifdef MUSB_ARB_ROUND_ROBIN_EN
      prio_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
`ifdef MUSB_ARB_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    done         = 1'b0;
    mem_address  = '0;
    mem_data_o   = '0;
    mem_wr       = '0;
    mem_enable   = 1'b0;
    iport_data_o = '0;
    iport_ready  = 1'b0;
    iport_error  = 1'b0;
    dport_data_o = '0;
    dport_ready  = 1'b0;
    dport_error  = 1'b0;
`ifdef MUSB_ARB_ROUND_ROBIN_EN
    prio_d       = prio_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MUSB_ARB_ROUND_ROBIN_EN
        if (dport_enable && (prio_q || !iport_enable)) state_d = OWN_D;
        else if (iport_enable)                         state_d = OWN_I;
`else
        if (dport_enable)      state_d = OWN_D;
        else if (iport_enable) state_d = OWN_I;
`endif
      end
      OWN_I: begin
        mem_address  = iport_address;
        mem_data_o   = iport_data_i;
        mem_wr       = iport_wr;
        mem_enable   = iport_enable;
        iport_data_o = mem_data_i;
        // error beats ready; the watchdog only fires when the slave is silent
        iport_ready  = iport_enable & mem_ready & ~mem_error;
        iport_error  = iport_enable & (mem_error | (wd_hit & ~mem_ready));
        done         = iport_enable & (mem_ready | mem_error | wd_hit);
        if (!iport_enable) state_d = IDLE;
        else if (done)     state_d = dport_enable ? OWN_D : IDLE;
`ifdef MUSB_ARB_ROUND_ROBIN_EN
        if (done) prio_d = 1'b1;
`endif
      end
      OWN_D: begin
        mem_address  = dport_address;
        mem_data_o   = dport_data_i;
        mem_wr       = dport_wr;
        mem_enable   = dport_enable;
        dport_data_o = mem_data_i;
        dport_ready  = dport_enable & mem_ready & ~mem_error;
        dport_error  = dport_enable & (mem_error | (wd_hit & ~mem_ready));
        done         = dport_enable & (mem_ready | mem_error | wd_hit);
        if (!dport_enable) state_d = IDLE;
        else if (done)     state_d = iport_enable ? OWN_I : IDLE;
`ifdef MUSB_ARB_ROUND_ROBIN_EN
        if (done) prio_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase

    // any change of owner (new grant, handoff, leave) restarts the watchdog
    if (state_q == IDLE || state_d != state_q) wdog_d = '0;
    else if (wdog_q == {CW{1'b1}})             wdog_d = wdog_q;
    else                                       wdog_d = wdog_q + CW'(1);
  end

endmodule

// File: tb/tb_musb_port_arbiter.sv
// Directed cycle-by-cycle vectors for musb_port_arbiter (TIMEOUT=8), plus an async-reset-in-transfer sequence.
module tb_musb_port_arbiter;

  localparam logic [31:0] IA = 32'h0000_0100;
  localparam logic [31:0] ID = 32'hA5A5_0001;
  localparam logic [3:0]  IW = 4'h0;
  localparam logic [31:0] DA = 32'h0000_0200;
  localparam logic [31:0] DD = 32'h1234_5678;
  localparam logic [3:0]  DW = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iport_address = IA, iport_data_i = ID;
  logic [3:0]  iport_wr = IW;
  logic        iport_enable = 1'b0;
  logic [31:0] iport_data_o;
  logic        iport_ready, iport_error;
  logic [31:0] dport_address = DA, dport_data_i = DD;
  logic [3:0]  dport_wr = DW;
  logic        dport_enable = 1'b0;
  logic [31:0] dport_data_o;
  logic        dport_ready, dport_error;
  logic [31:0] mem_address, mem_data_o;
  logic [3:0]  mem_wr;
  logic        mem_enable;
  logic [31:0] mem_data_i = '0;
  logic        mem_ready = 1'b0, mem_error = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  musb_port_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .iport_address(iport_address), .iport_data_i(iport_data_i), .iport_wr(iport_wr),
    .iport_enable(iport_enable), .iport_data_o(iport_data_o), .iport_ready(iport_ready),
    .iport_error(iport_error),
    .dport_address(dport_address), .dport_data_i(dport_data_i), .dport_wr(dport_wr),
    .dport_enable(dport_enable), .dport_data_o(dport_data_o), .dport_ready(dport_ready),
    .dport_error(dport_error),
    .mem_address(mem_address), .mem_data_o(mem_data_o), .mem_wr(mem_wr),
    .mem_enable(mem_enable), .mem_data_i(mem_data_i), .mem_ready(mem_ready),
    .mem_error(mem_error)
  );

  typedef struct {
    string       name;
    logic        r, ien, den;
    logic [31:0] md;
    logic        mr, me;
    int          own;   // expected owner: 0 none, 1 iport, 2 dport
    logic        irdy, ierr, drdy, derr;
  } vec_t;

  function automatic vec_t v(string n, logic r, logic ie, logic de, logic [31:0] md,
                             logic mr, logic me, int own,
                             logic ir, logic ier, logic dr, logic der);
    vec_t x;
    x.name = n; x.r = r; x.ien = ie; x.den = de; x.md = md; x.mr = mr; x.me = me;
    x.own = own; x.irdy = ir; x.ierr = ier; x.drdy = dr; x.derr = der;
    return x;
  endfunction

  task automatic chk(string n, logic [136:0] act, logic [136:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic chk_row(vec_t x);
    logic [31:0] ea, ed, eido, eddo;
    logic [3:0]  ew;
    logic        ee;
    ea = '0; ed = '0; ew = '0; ee = 1'b0; eido = '0; eddo = '0;
    if (x.own == 1) begin
      ea = IA; ed = ID; ew = IW; ee = x.ien; eido = x.md;
    end else if (x.own == 2) begin
      ea = DA; ed = DD; ew = DW; ee = x.den; eddo = x.md;
    end
    chk(x.name,
        {mem_address, mem_data_o, mem_wr, mem_enable, iport_data_o, iport_ready, iport_error,
         dport_data_o, dport_ready, dport_error},
        {ea, ed, ew, ee, eido, x.irdy, x.ierr, eddo, x.drdy, x.derr});
  endtask

  vec_t tbl[$];

  initial begin
    // reset and idle
    for (int i = 0; i < 3; i++) tbl.push_back(v("t1_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("t1_idle", 0, 0, 0, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("t1_idle", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    // iport read, slave ready in the third OWN cycle
    tbl.push_back(v("t2_req", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("t2_own1", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v("t2_own2", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v("t2_ready", 0, 1, 0, 32'hDEAD_BEEF, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v("t2_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // simultaneous request: dport first, iport handed over without a dead cycle
    tbl.push_back(v("t3_req", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("t3_d_wait", 0, 1, 1, 32'h55, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(v("t3_d_ready", 0, 1, 1, 32'h66, 1, 0, 2, 0, 0, 1, 0));
    tbl.push_back(v("t3_i_own", 0, 1, 0, 32'h77, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v("t3_i_ready", 0, 1, 0, 32'h1111_2222, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v("t3_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // watchdog on dport with iport waiting, then handoff and a normal iport transfer
    tbl.push_back(v("t4_req", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 7; i++) tbl.push_back(v("t4_d_hang", 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(v("t4_d_timeout", 0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 1));
    tbl.push_back(v("t4_i_own1", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v("t4_i_own2", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(v("t4_i_ready", 0, 1, 0, 32'hCAFE_F00D, 1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v("t4_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // ready and error together, then dport abort with a late ready
    tbl.push_back(v("t5_req", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("t5_rdy_err", 0, 1, 0, 32'h0BAD_0BAD, 1, 1, 1, 0, 1, 0, 0));
    tbl.push_back(v("t5_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("t5_d_req", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v("t5_d_wait", 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(v("t5_d_abort", 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(v("t5_late_rdy", 0, 0, 0, 32'h9999, 1, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      rst = tbl[i].r; iport_enable = tbl[i].ien; dport_enable = tbl[i].den;
      mem_data_i = tbl[i].md; mem_ready = tbl[i].mr; mem_error = tbl[i].me;
      @(negedge clk);
      chk_row(tbl[i]);
    end

    // async reset while dport owns the port
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_data_i = '0; dport_enable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_own_d", {105'b0, mem_address}, {105'b0, DA});
    #2 rst = 1'b1;
    #1;
    chk("t6_async_zero", {68'b0, mem_address, mem_data_o, mem_wr, mem_enable, dport_ready, dport_error, dport_data_o[0]},
        137'b0);
    dport_enable = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_after", {100'b0, mem_address, mem_wr, mem_enable}, 137'b0);
    @(posedge clk); #1 dport_enable = 1'b1;
    @(negedge clk);
    chk("t6_regrant_wait", {136'b0, mem_enable}, 137'b0);
    @(posedge clk); #1 mem_ready = 1'b1; mem_data_i = 32'h4242_4242;
    @(negedge clk);
    chk("t6_regrant", {mem_address, mem_enable, dport_ready, dport_data_o, 71'b0},
        {DA, 1'b1, 1'b1, 32'h4242_4242, 71'b0});
    @(posedge clk); #1 dport_enable = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("t6_done_idle", {136'b0, mem_enable}, 137'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
